// File: rtl/apb_arb.sv
// ---------------------------------------------------------------------------
// apb_arb -- two-master round-robin arbiter for a single-transfer APB-style
// register bus, with a watchdog that force-completes stuck slave transfers.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_mX_penable/pwrite/...  master X request (held until o_mX_pready seen)
//   o_mX_pready/prdata       master X one-cycle completion pulse and read data
//   o_penable/pwrite/...     registered slave-side request
//   i_pready, i_prdata       slave completion and read data
//   o_grant                  index of the current/last granted master
//   o_timeout                one-cycle pulse alongside a watchdog completion
// ---------------------------------------------------------------------------
module apb_arb #(
    parameter int unsigned TIMEOUT_CYC   = 1024,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_penable,
    input  logic        i_m0_pwrite,
    input  logic [31:0] i_m0_paddr,
    input  logic [31:0] i_m0_pwdata,
    output logic        o_m0_pready,
    output logic [31:0] o_m0_prdata,
    input  logic        i_m1_penable,
    input  logic        i_m1_pwrite,
    input  logic [31:0] i_m1_paddr,
    input  logic [31:0] i_m1_pwdata,
    output logic        o_m1_pready,
    output logic [31:0] o_m1_prdata,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [31:0] o_paddr,
    output logic [31:0] o_pwdata,
    input  logic        i_pready,
    input  logic [31:0] i_prdata,
    output logic        o_grant,
    output logic        o_timeout
);
    // Counter is wide enough to reach TIMEOUT_CYC, never narrower than 16 bits.
    localparam int unsigned WD_NEED = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned WD_W    = (WD_NEED > 16) ? WD_NEED : 16;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC == 0) ? '0 : WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              m0_rdy_q, m0_rdy_d, m1_rdy_q, m1_rdy_d;
    logic [31:0]       m0_rd_q, m0_rd_d, m1_rd_q, m1_rd_d;
    logic              to_q, to_d;
    logic              win;
    logic              wd_fire;
    logic [31:0]       rsp_data;

    // With both requesting, the master that did not win last time goes next.
    assign win      = (i_m0_penable && i_m1_penable) ? ~last_q : i_m1_penable;
    assign wd_fire  = (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);
    // A real slave ready always beats a coinciding watchdog expiry.
    assign rsp_data = i_pready ? i_prdata : TIMEOUT_RDATA;

    always_comb begin
        state_d   = state_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        grant_d   = grant_q;
        last_d    = last_q;
        wd_d      = wd_q;
        m0_rdy_d  = m0_rdy_q;
        m1_rdy_d  = m1_rdy_q;
        m0_rd_d   = m0_rd_q;
        m1_rd_d   = m1_rd_q;
        to_d      = to_q;
        case (state_q)
            IDLE: begin
                if (i_m0_penable || i_m1_penable) begin
                    penable_d = 1'b1;
                    pwrite_d  = win ? i_m1_pwrite : i_m0_pwrite;
                    paddr_d   = win ? i_m1_paddr  : i_m0_paddr;
                    pwdata_d  = win ? i_m1_pwdata : i_m0_pwdata;
                    grant_d   = win;
                    last_d    = win;
                    wd_d      = '0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (wd_q != '1) wd_d = wd_q + WD_W'(1);
                if (i_pready || wd_fire) begin
                    penable_d = 1'b0;
                    to_d      = ~i_pready;
                    if (grant_q) begin
                        m1_rdy_d = 1'b1;
                        m1_rd_d  = rsp_data;
                    end else begin
                        m0_rdy_d = 1'b1;
                        m0_rd_d  = rsp_data;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // The completing master's penable is still stale here; ignore both.
                m0_rdy_d = 1'b0;
                m1_rdy_d = 1'b0;
                to_d     = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            wd_q      <= '0;
            m0_rdy_q  <= 1'b0;
            m1_rdy_q  <= 1'b0;
            m0_rd_q   <= '0;
            m1_rd_q   <= '0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            m0_rdy_q  <= m0_rdy_d;
            m1_rdy_q  <= m1_rdy_d;
            m0_rd_q   <= m0_rd_d;
            m1_rd_q   <= m1_rd_d;
            to_q      <= to_d;
        end
    end

    assign o_penable   = penable_q;
    assign o_pwrite    = pwrite_q;
    assign o_paddr     = paddr_q;
    assign o_pwdata    = pwdata_q;
    assign o_grant     = grant_q;
    assign o_timeout   = to_q;
    assign o_m0_pready = m0_rdy_q;
    assign o_m0_prdata = m0_rd_q;
    assign o_m1_pready = m1_rdy_q;
    assign o_m1_prdata = m1_rd_q;

endmodule

// File: tb/tb_apb_arb.sv
// ---------------------------------------------------------------------------
// tb_apb_arb -- scoreboard bench for apb_arb. Master agents replay command
// queues, a slave model checks each slave-side request against an expected
// queue and answers after a programmed delay, and a response monitor pops
// per-master expected responses whenever a pready pulse appears.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_arb;
    localparam int TO = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        m0_pen, m0_pwr, m1_pen, m1_pwr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_rdy, m1_rdy;
    logic [31:0] m0_rdata, m1_rdata;
    logic        o_penable, o_pwrite, o_grant, o_timeout;
    logic [31:0] o_paddr, o_pwdata;
    logic        i_pready;
    logic [31:0] i_prdata;

    apb_arb #(.TIMEOUT_CYC(TO), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_penable(m0_pen), .i_m0_pwrite(m0_pwr), .i_m0_paddr(m0_addr), .i_m0_pwdata(m0_wdata),
        .o_m0_pready(m0_rdy), .o_m0_prdata(m0_rdata),
        .i_m1_penable(m1_pen), .i_m1_pwrite(m1_pwr), .i_m1_paddr(m1_addr), .i_m1_pwdata(m1_wdata),
        .o_m1_pready(m1_rdy), .o_m1_prdata(m1_rdata),
        .o_penable(o_penable), .o_pwrite(o_pwrite), .o_paddr(o_paddr), .o_pwdata(o_pwdata),
        .i_pready(i_pready), .i_prdata(i_prdata),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
    typedef struct { logic [31:0] rdata; logic to; } rsp_t;
    typedef struct {
        logic m; logic wr; logic [31:0] addr; logic [31:0] wdata;
        int delay; logic [31:0] rdata; int lat; int gap; int ncyc;
    } slv_t;

    cmd_t cq0[$], cq1[$];
    rsp_t eq0[$], eq1[$];
    slv_t sq[$];

    int n_checks = 0, n_pass = 0;
    int cyc = 0, rst_epoch = 0, last_start = 0;
    int req_cyc[2];
    bit busy[2];
    bit slv_busy = 0;
    logic [31:0] last_rd[2];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    task automatic drive(input int m, input logic en, input cmd_t c);
        if (m == 0) begin m0_pen = en; m0_pwr = c.wr; m0_addr = c.addr; m0_wdata = c.wdata; end
        else        begin m1_pen = en; m1_pwr = c.wr; m1_addr = c.addr; m1_wdata = c.wdata; end
    endtask

    // Master agent: hold the request until pready is seen (or a reset drops it),
    // then release or present the next command on the following edge.
    task automatic agent(input int m);
        cmd_t c;
        int ep, n;
        bit done, rdy;
        c.wr = 0; c.addr = 0; c.wdata = 0;
        drive(m, 1'b0, c);
        busy[m] = 0;
        forever begin
            @(posedge i_clk); #1;
            if ((m == 0 ? cq0.size() : cq1.size()) == 0) begin
                if (m == 0) m0_pen = 1'b0; else m1_pen = 1'b0;
            end else begin
                if (m == 0) c = cq0.pop_front(); else c = cq1.pop_front();
                drive(m, 1'b1, c);
                ep = rst_epoch; req_cyc[m] = cyc; busy[m] = 1; done = 0; n = 0;
                while (!done) begin
                    @(negedge i_clk); n++;
                    rdy = (m == 0) ? m0_rdy : m1_rdy;
                    if (rst_epoch != ep) done = 1;
                    else if (rdy) done = 1;
                    else if (n > 300) begin
                        chk($sformatf("m%0d pready wait", m), 0, 1);
                        done = 1;
                    end
                end
                busy[m] = 0;
            end
        end
    endtask

    initial agent(0);
    initial agent(1);

    // Response monitor.
    task automatic mon(input int m);
        rsp_t r;
        logic [31:0] rd, rd_o;
        logic rdy_o;
        if (m == 0) begin rd = m0_rdata; rd_o = m1_rdata; rdy_o = m1_rdy; end
        else        begin rd = m1_rdata; rd_o = m0_rdata; rdy_o = m0_rdy; end
        if ((m == 0 ? eq0.size() : eq1.size()) == 0) begin
            chk($sformatf("m%0d unexpected pready", m), 1, 0);
            return;
        end
        if (m == 0) r = eq0.pop_front(); else r = eq1.pop_front();
        chk($sformatf("m%0d prdata", m), rd, r.rdata);
        chk($sformatf("m%0d timeout flag", m), o_timeout, r.to);
        chk($sformatf("m%0d other pready", m), rdy_o, 0);
        chk($sformatf("m%0d other prdata hold", m), rd_o, last_rd[1-m]);
        last_rd[m] = rd;
    endtask

    always @(negedge i_clk) if (i_rst_n) begin
        if (m0_rdy) mon(0);
        if (m1_rdy) mon(1);
        if (o_timeout && !m0_rdy && !m1_rdy) chk("timeout without pready", 1, 0);
    end

    // Slave model.
    initial begin
        slv_t s;
        int n;
        i_pready = 0; i_prdata = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_penable) begin
                slv_busy = 1;
                if (sq.size() == 0) begin
                    chk("slave unexpected request", 1, 0);
                    s.delay = -1; s.ncyc = 0;
                end else begin
                    s = sq.pop_front();
                    chk("grant", o_grant, s.m);
                    chk("pwrite", o_pwrite, s.wr);
                    chk("paddr", o_paddr, s.addr);
                    chk("pwdata", o_pwdata, s.wdata);
                    if (s.lat >= 0) chk("request latency", cyc - req_cyc[s.m], s.lat);
                    if (s.gap > 0) chk("bus spacing", cyc - last_start, s.gap);
                end
                last_start = cyc;
                n = 1;
                if (s.delay >= 0) begin
                    repeat (s.delay) begin @(negedge i_clk); n++; end
                    i_pready = 1; i_prdata = s.rdata;
                end
                forever begin
                    @(negedge i_clk);
                    if (!o_penable || n > 60) break;
                    n++;
                end
                i_pready = 0;
                if (o_penable) chk("penable stuck", 1, 0);
                else if (s.ncyc > 0) chk("xfer cycles", n, s.ncyc);
                slv_busy = 0;
            end
        end
    end

    task automatic xfer(input logic m, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic [31:0] srd, input int lat, input int gap, input int ncyc,
                        input bit rsp, input logic [31:0] erd, input logic eto);
        slv_t s; cmd_t c; rsp_t r;
        s.m = m; s.wr = wr; s.addr = addr; s.wdata = wdata; s.delay = delay;
        s.rdata = srd; s.lat = lat; s.gap = gap; s.ncyc = ncyc;
        sq.push_back(s);
        c.wr = wr; c.addr = addr; c.wdata = wdata;
        r.rdata = erd; r.to = eto;
        if (m == 0) begin cq0.push_back(c); if (rsp) eq0.push_back(r); end
        else        begin cq1.push_back(c); if (rsp) eq1.push_back(r); end
    endtask

    function automatic bit all_idle();
        return cq0.size() == 0 && cq1.size() == 0 && sq.size() == 0 && eq0.size() == 0 &&
               eq1.size() == 0 && !busy[0] && !busy[1] && !slv_busy;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (!all_idle() && n < 400) begin @(negedge i_clk); n++; end
        chk({name, " completes"}, all_idle(), 1);
        cq0.delete(); cq1.delete(); sq.delete(); eq0.delete(); eq1.delete();
        repeat (2) @(negedge i_clk);
    endtask

    task automatic rst_assert();
        rst_epoch++;
        i_rst_n = 0;
        #1;
        chk("reset ctl", {o_penable, o_pwrite, o_grant, o_timeout, m0_rdy, m1_rdy}, 0);
        chk("reset slave bus", {o_paddr, o_pwdata}, 0);
        chk("reset prdata", {m0_rdata, m1_rdata}, 0);
        last_rd[0] = 0; last_rd[1] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        last_rd[0] = 0; last_rd[1] = 0;
        i_rst_n = 1;
        #2;
        rst_assert();
        repeat (3) @(negedge i_clk);
        i_rst_n = 1;

        // single m0 read, ready after 2 extra cycles
        xfer(0, 0, 32'h10, 0, 2, 32'hCAFE_0001, 1, 0, 3, 1, 32'hCAFE_0001, 0);
        drain("single m0 read");

        // both masters after reset, 4 each: strict alternation starting with m0
        rst_assert();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            xfer(0, 0, 32'h100 + i*8, 0, 1, 32'hA000_0000 + i, (i == 0) ? 1 : -1, (i == 0) ? 0 : 4, 2,
                 1, 32'hA000_0000 + i, 0);
            xfer(1, 0, 32'h104 + i*8, 0, 1, 32'hB000_0000 + i, -1, 4, 2, 1, 32'hB000_0000 + i, 0);
        end
        drain("round robin");

        // m1 write with immediate ready, then a back-to-back read 3 cycles apart
        xfer(1, 1, 32'h4, 32'h1234_5678, 0, 32'h0, 1, 0, 1, 1, 32'h0, 0);
        xfer(1, 0, 32'h8, 0, 0, 32'h5555_AAAA, 1, 3, 1, 1, 32'h5555_AAAA, 0);
        drain("m1 write");

        // slave never ready: watchdog after 8 cycles, then a normal transfer
        xfer(0, 0, 32'h20, 0, -1, 32'h0, 1, 0, TO, 1, 32'hDEAD_BEEF, 1);
        xfer(0, 0, 32'h24, 0, 1, 32'h7777_0001, 1, TO + 2, 2, 1, 32'h7777_0001, 0);
        drain("watchdog");

        // ready on the same cycle the watchdog would fire
        xfer(1, 0, 32'h30, 0, TO - 1, 32'h0BAD_F00D, 1, 0, TO, 1, 32'h0BAD_F00D, 0);
        drain("ready vs watchdog");

        // reset in the middle of an m0 transfer; both then pending -> m0 first
        xfer(0, 0, 32'h40, 0, -1, 32'h0, 1, 0, 0, 0, 32'h0, 0);
        n = 0;
        while (!o_penable && n < 20) begin @(negedge i_clk); n++; end
        chk("penable before reset", o_penable, 1);
        repeat (2) @(negedge i_clk);
        #2;
        rst_assert();
        xfer(0, 0, 32'h50, 0, 0, 32'h1111_0000, -1, 0, 1, 1, 32'h1111_0000, 0);
        xfer(1, 0, 32'h54, 0, 0, 32'h2222_0000, -1, 0, 1, 1, 32'h2222_0000, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1;
        drain("reset both pending");

        // reset with only m1 pending
        rst_assert();
        xfer(1, 1, 32'h60, 32'hFACE_0060, 0, 32'h0, -1, 0, 1, 1, 32'h0, 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1;
        drain("reset m1 pending");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_arb.md
Name: apb_arb

Overview:
- Two-master arbiter for the single-transfer APB-style register bus driven by the debug command engine.
- Master 0 is the UART debug command path; master 1 is the on-chip core or another requester.
- The block grants the shared slave port to one master at a time using round-robin, registers the selected request, and returns the response only to the granted master.
- A watchdog terminates transfers whose slave never asserts ready.

Parameters:
TIMEOUT_CYC, 1024, slave-phase cycle limit before forced completion; 0 disables the watchdog
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out transfer

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_m0_penable  input  1  master 0 transfer request, held until o_m0_pready seen
i_m0_pwrite  input  1  master 0 write(1)/read(0)
i_m0_paddr  input  32  master 0 address
i_m0_pwdata  input  32  master 0 write data
o_m0_pready  output  1  master 0 completion pulse
o_m0_prdata  output  32  master 0 read data, valid with o_m0_pready
i_m1_penable, i_m1_pwrite, i_m1_paddr, i_m1_pwdata, o_m1_pready, o_m1_prdata  same directions/widths/meaning for master 1
o_penable  output  1  slave-side transfer enable
o_pwrite  output  1  slave-side write
o_paddr  output  32  slave-side address
o_pwdata  output  32  slave-side write data
i_pready  input  1  slave completion
i_prdata  input  32  slave read data
o_grant  output  1  index of current/last granted master
o_timeout  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs are 0.
  - State is IDLE.
  - Last-grant register is 1, so master 0 wins the first tie.
  - Watchdog counter is 0.
  - An in-flight transfer is dropped without any pready to the master.
- Master contract: penable and its qualifiers stay stable from assertion until the cycle the master samples its pready=1. The master deasserts penable on that same edge.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If any i_mX_penable=1, select a winner. With one requester, that requester wins. With both, the master not equal to the last-grant register wins.
  - On the edge: register pwrite/paddr/pwdata from the winner, set o_penable=1, set o_grant and last-grant to the winner, clear the watchdog, move to XFER.
  - Latency: request in cycle N gives o_penable=1 in cycle N+1.
- XFER:
  - Slave outputs stay stable. The watchdog increments each cycle.
  - If i_pready=1:
    - On the edge: o_penable=0.
    - o_mG_pready=1 and o_mG_prdata=i_prdata, where G is the granted master; for writes, prdata is still captured but is don't-care.
    - Move to DONE.
  - Else, if TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC-1:
    - Same completion as above, but prdata=TIMEOUT_RDATA and o_timeout pulses.
    - Move to DONE.
  - If i_pready and the timeout coincide, i_pready wins and there is no o_timeout.
- DONE:
  - o_mG_pready is high for exactly this cycle.
  - Both masters' penable are ignored, since the completing master still shows a stale request.
  - On the edge: pready=0, move to IDLE.
- Response data:
  - o_mX_prdata holds its last value until that master's next completion.
  - The non-granted master's pready/prdata never change.
- Bus spacing: minimum 3 cycles per transfer, from request to next possible o_penable. Back-to-back requests from both masters alternate strictly.
- A request arriving while another transfer is busy waits; there is no preemption.
- i_pready while o_penable=0 is ignored.
- The watchdog counter is at least 16 bits (saturating width sized to TIMEOUT_CYC) and does not wrap before firing.

Test Plan:
- Single m0 read, addr 32'h0000_0010, slave pready after 2 cycles with prdata 32'hCAFE_0001 -> o_penable rises 1 cycle after request; o_m0_pready pulses once with prdata CAFE_0001; o_m1_pready stays 0.
- m0 and m1 request in the same cycle after reset, 4 repeated transfers each -> grant order 0,1,0,1,…; each master sees exactly 4 pready pulses with the correct data.
- m1 write 32'h1234_5678 to 32'h0000_0004 with slave ready in its first cycle -> slave sees pwrite=1 and the correct addr/data; next IDLE accepts a new request 3 cycles after the original request.
- TIMEOUT_CYC=8, slave never ready -> after 8 XFER cycles, o_timeout pulses, master gets prdata DEAD_BEEF, o_penable drops; a following transfer completes normally.
- i_pready and timeout in the same cycle -> slave data is returned and o_timeout stays 0.
- Assert i_rst_n=0 mid-XFER -> all outputs 0 immediately; after release, a pending m1 request with no m0 request is granted normally; with both pending, m0 wins.
